// File: rtl/uart_pkg.sv
// Shared constants for the 16-byte UART link: default timing, packet geometry
// and the receiver state encoding.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_HALF_BIT     = 434;
    localparam int DEFAULT_BYTES        = 16;
    localparam int DEFAULT_DATA_W       = 8 * DEFAULT_BYTES;

    // Bit-time counter width; must hold CLKS_PER_BIT-1.
    localparam int CNT_W = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BITS  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_FULL  = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a 1->0 start-edge detector.
// All flops reset to the idle-high line level so reset never fakes an edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic start_edge
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= rx;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign rx_s       = sync_reg;
    assign start_edge = prev_reg & ~sync_reg;

endmodule

// File: rtl/uart_rx_block.sv
// 8N1 receiver that gathers BYTES bytes into one packet word (byte 0 in the
// low bits) and holds it with a RECEIVED/ACKNOWLEDGE handshake.
module uart_rx_block
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = DEFAULT_HALF_BIT,
    parameter int BYTES        = DEFAULT_BYTES
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX,
    input  logic               ACKNOWLEDGE,
    output logic [8*BYTES-1:0] DATA,
    output logic               RECEIVED,
    output logic               FRAME_ERR
);

    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PKT_W  = 8 * BYTES;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(BYTES - 1);

    logic rx_s;
    logic start_edge;

    logic [2:0]        state_reg,    state_next;
    logic [CNT_W-1:0]  cnt_reg,      cnt_next;
    logic [2:0]        bit_cnt_reg,  bit_cnt_next;
    logic [BCNT_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic [7:0]        shift_reg,    shift_next;
    logic [PKT_W-1:0]  buf_reg,      buf_next;
    logic [PKT_W-1:0]  data_reg,     data_next;
    logic              received_reg, received_next;
    logic              frame_err_reg, frame_err_next;

    logic              frame_set;
    logic [PKT_W-1:0]  buf_written;

    uart_rx_sync u_sync (
        .clk        (CLK),
        .rst        (RST),
        .rx         (RX),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    // Packet buffer with the just-completed byte dropped into slot byte_cnt.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_slot
            assign buf_written[8*gi +: 8] = (byte_cnt_reg == BCNT_W'(gi)) ?
                                            shift_reg : buf_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        buf_next      = buf_reg;
        data_next     = data_reg;
        received_next = received_reg;
        frame_set     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                if (start_edge) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_s ? ST_IDLE : ST_BITS;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_BITS: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    if (rx_s) begin
                        buf_next = buf_written;
                        if (byte_cnt_reg == BYTE_LAST) begin
                            data_next     = buf_written;
                            byte_cnt_next = '0;
                            received_next = 1'b1;
                            state_next    = ST_FULL;
                        end else begin
                            byte_cnt_next = byte_cnt_reg + BCNT_W'(1);
                        end
                    end else begin
                        // Bad stop bit aborts the whole packet, not just the byte.
                        frame_set     = 1'b1;
                        byte_cnt_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_FULL: begin
                if (ACKNOWLEDGE) begin
                    received_next = 1'b0;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (frame_set) begin
            frame_err_next = 1'b1;
        end else if (ACKNOWLEDGE) begin
            frame_err_next = 1'b0;
        end else begin
            frame_err_next = frame_err_reg;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            shift_reg     <= '0;
            buf_reg       <= '0;
            data_reg      <= '0;
            received_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            shift_reg     <= shift_next;
            buf_reg       <= buf_next;
            data_reg      <= data_next;
            received_reg  <= received_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign DATA      = data_reg;
    assign RECEIVED  = received_reg;
    assign FRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_block.sv
// Directed-sequence bench for uart_rx_block with random payloads, compared
// against a byte-level packet model (queue of accepted bytes).
module tb_uart_rx_block;

    localparam int BIT  = 32;
    localparam int HALF = 16;
    localparam int NB   = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic            RX;
    logic            ACKNOWLEDGE;
    logic [8*NB-1:0] DATA;
    logic            RECEIVED;
    logic            FRAME_ERR;

    int errors = 0;
    int checks = 0;

    logic [7:0]      m_q[$];
    logic [8*NB-1:0] m_data;
    logic            m_full;
    logic            m_ferr;

    uart_rx_block #(
        .CLKS_PER_BIT (BIT),
        .HALF_BIT     (HALF),
        .BYTES        (NB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX          (RX),
        .ACKNOWLEDGE (ACKNOWLEDGE),
        .DATA        (DATA),
        .RECEIVED    (RECEIVED),
        .FRAME_ERR   (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [8*NB-1:0] obs,
                              input logic [8*NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_data({tag, "_data"}, DATA, m_data);
        check1({tag, "_received"}, RECEIVED, m_full);
        check1({tag, "_frame_err"}, FRAME_ERR, m_ferr);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data = '0;
        m_full = 1'b0;
        m_ferr = 1'b0;
    endtask

    // A byte counts only when the receiver is not holding a packet.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (m_full) return;
        if (!stop_ok) begin
            m_ferr = 1'b1;
            m_q.delete();
            return;
        end
        m_q.push_back(b);
        if (m_q.size() == NB) begin
            for (int k = 0; k < NB; k++) m_data[8*k +: 8] = m_q[k];
            m_full = 1'b1;
            m_q.delete();
        end
    endtask

    task automatic drive(input logic v, input int n);
        RX = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int period);
        drive(1'b0, period);
        for (int i = 0; i < 8; i++) drive(b[i], period);
        drive(stop_ok, period);
        if (!stop_ok) drive(1'b1, period);
        drive(1'b1, $urandom_range(1, 8));
        model_byte(b, stop_ok);
        $display("byte 0x%02h stop=%0d period=%0d RECEIVED=%0b FRAME_ERR=%0b",
                 b, stop_ok, period, RECEIVED, FRAME_ERR);
        check_outputs("byte");
    endtask

    task automatic send_random_packet(input int period);
        for (int i = 0; i < NB; i++) send_byte(8'($urandom), 1'b1, period);
    endtask

    task automatic ack();
        ACKNOWLEDGE = 1'b1;
        @(negedge CLK);
        ACKNOWLEDGE = 1'b0;
        m_full = 1'b0;
        m_ferr = 1'b0;
        $display("ack RECEIVED=%0b FRAME_ERR=%0b", RECEIVED, FRAME_ERR);
        check_outputs("ack");
        drive(1'b1, BIT);
    endtask

    logic [8*NB-1:0] held;
    logic [7:0]      b7;

    initial begin
        RST = 1'b1;
        RX = 1'b1;
        ACKNOWLEDGE = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_outputs("reset");
        RST = 1'b0;
        drive(1'b1, 4);
        check_outputs("post_reset");

        // Clean packet 0x00..0x0F.
        for (int i = 0; i < NB; i++) send_byte(8'(i), 1'b1, BIT);
        check_data("clean_data_const", DATA, 128'h0F0E0D0C0B0A09080706050403020100);
        ack();
        check_data("clean_data_after_ack", DATA, 128'h0F0E0D0C0B0A09080706050403020100);

        // Framing error on byte 5, then a clean 0xA5 packet.
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, BIT);
        send_byte(8'($urandom), 1'b0, BIT);
        check1("frame_err_set", FRAME_ERR, 1'b1);
        for (int i = 0; i < NB; i++) send_byte(8'hA5, 1'b1, BIT);
        check_data("a5_data", DATA, {NB{8'hA5}});
        ack();
        check1("frame_err_cleared", FRAME_ERR, 1'b0);

        // Glitch shorter than half a bit: false start, nothing stored.
        drive(1'b0, HALF / 2 - 2);
        drive(1'b1, 3 * BIT);
        $display("glitch RECEIVED=%0b FRAME_ERR=%0b", RECEIVED, FRAME_ERR);
        check_outputs("glitch");
        send_random_packet(BIT);

        // Overrun while holding a packet.
        held = DATA;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, BIT);
        check_data("overrun_hold", DATA, held);
        ack();
        send_random_packet(BIT);
        ack();

        // Reset during bit 3 of byte 7.
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1, BIT);
        b7 = 8'($urandom);
        drive(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(b7[i], BIT);
        drive(b7[3], BIT / 2);
        #2;
        RST = 1'b1;
        RX = 1'b1;
        #1;
        model_reset();
        $display("async reset RECEIVED=%0b FRAME_ERR=%0b", RECEIVED, FRAME_ERR);
        check_outputs("async_reset");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        drive(1'b1, 2 * BIT);
        send_random_packet(BIT);
        ack();

        // Baud skew on both sides of nominal.
        send_random_packet(BIT - 1);
        check1("skew_slow_ferr", FRAME_ERR, 1'b0);
        ack();
        send_random_packet(BIT + 1);
        check1("skew_fast_ferr", FRAME_ERR, 1'b0);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
